// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: opcode encodings,
// the offset-table entry layout and the loop-tracking state encoding.
// Pure declarations; no clocked logic and no flow control.
package branch_pkg;

  localparam logic [3:0] OP_LDC  = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_BN   = 4'b1101;
  localparam logic [3:0] OP_BR   = 4'b1110;
  localparam logic [3:0] OP_LOOP = 4'b1111;

  // Offset-table entry: sign = 1 means the fetch unit subtracts the magnitude.
  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
  } boffs_t;

  typedef enum logic {
    LS_IDLE    = 1'b0,
    LS_LOOPING = 1'b1
  } loop_state_e;

  // The four branch opcodes are exactly the ones with the top two bits set.
  function automatic logic is_branch_op(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/offset_lut.sv
// Branch offset table: LUT_DEPTH x 9-bit register file, async-cleared to +0.
// Latency: write lands on the rising edge; read is combinational (old data during a same-cycle write).
// No backpressure: a write is always accepted.
// Ports: clk_i, rst_ni | we_i, waddr_i, wdata_i (write port) | raddr_i -> rdata_o (read port).
module offset_lut
  import branch_pkg::*;
#(
  parameter int LUT_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  boffs_t            wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output boffs_t            rdata_o
);

  boffs_t mem_q [LUT_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: decodes instr against Z/N flags, loop counter and offset table.
// Latency: branch_en/bSIGN/bOFFSET combinational in the instr cycle; state updates on the next edge.
// No backpressure; halt freezes flags, loop counter, FSM and taken counter (table writes still land).
// Ports: CLK, init_n | instr, halt, flag_we, alu_zero, alu_neg, acc_in, lut_we/addr/wdata (in)
//        | branch_en, bSIGN, bOFFSET (fetch request), loop_cnt, taken_cnt (observability).
module branch_unit
  import branch_pkg::*;
#(
  parameter int LUT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic [8:0]       instr,
  input  logic             halt,
  input  logic             flag_we,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic [7:0]       acc_in,
  input  logic             lut_we,
  input  logic [3:0]       lut_addr,
  input  logic [8:0]       lut_wdata,
  output logic             branch_en,
  output logic             bSIGN,
  output logic [7:0]       bOFFSET,
  output logic [7:0]       loop_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0] opcode;
  logic [3:0] idx;
  logic       rsvd_unused;

  assign opcode      = instr[8:5];
  assign idx         = instr[3:0];
  assign rsvd_unused = instr[4];

  logic             z_q, z_d;
  logic             n_q, n_d;
  logic [7:0]       loop_q, loop_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  loop_state_e      state_q, state_d;

  boffs_t lut_wr;
  boffs_t lut_rd;
  logic   is_br;
  logic   take;

  assign lut_wr = lut_wdata;

  offset_lut #(
    .LUT_DEPTH(LUT_DEPTH),
    .ADDR_W   (4)
  ) u_lut (
    .clk_i  (CLK),
    .rst_ni (init_n),
    .we_i   (lut_we),
    .waddr_i(lut_addr),
    .wdata_i(lut_wr),
    .raddr_i(idx),
    .rdata_o(lut_rd)
  );

  // Branch decision always uses the registered (pre-edge) flags.
  always_comb begin
    is_br = is_branch_op(opcode);
    take  = 1'b0;
    case (opcode)
      OP_BZ:   take = z_q;
      OP_BN:   take = n_q;
      OP_BR:   take = 1'b1;
      OP_LOOP: take = (loop_q != 8'd0);
      default: take = 1'b0;
    endcase
  end

  assign branch_en = take & ~halt;
  // Offset is driven for every branch opcode, taken or not.
  assign bSIGN     = is_br ? lut_rd.sign : 1'b0;
  assign bOFFSET   = is_br ? lut_rd.mag  : 8'd0;
  assign loop_cnt  = loop_q;
  assign taken_cnt = taken_q;

  always_comb begin
    z_d     = z_q;
    n_d     = n_q;
    loop_d  = loop_q;
    taken_d = taken_q;
    state_d = state_q;
    if (!halt) begin
      if (flag_we) begin
        z_d = alu_zero;
        n_d = alu_neg;
      end
      case (opcode)
        OP_LDC: begin
          loop_d  = acc_in;
          state_d = (acc_in != 8'd0) ? LS_LOOPING : LS_IDLE;
        end
        OP_LOOP: begin
          // Counter parks at zero rather than wrapping.
          if (loop_q != 8'd0) loop_d = loop_q - 8'd1;
          if (loop_q <= 8'd1) state_d = LS_IDLE;
        end
        default: ;
      endcase
      if (branch_en && !(&taken_q)) taken_d = taken_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      loop_q  <= 8'd0;
      taken_q <= '0;
      state_q <= LS_IDLE;
    end else begin
      z_q     <= z_d;
      n_q     <= n_d;
      loop_q  <= loop_d;
      taken_q <= taken_d;
      state_q <= state_d;
    end
  end

  // LOOPING exactly while the counter is non-zero.
  a_state_tracks_cnt: assert property (
    @(posedge CLK) disable iff (!init_n)
    (state_q == LS_LOOPING) == (loop_q != 8'd0)
  );

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  import branch_pkg::*;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          init_n = 1'b0;
  logic [8:0]    instr;
  logic          halt, flag_we, alu_zero, alu_neg, lut_we;
  logic [7:0]    acc_in;
  logic [3:0]    lut_addr;
  logic [8:0]    lut_wdata;
  logic          branch_en, bSIGN;
  logic [7:0]    bOFFSET, loop_cnt;
  logic [CW-1:0] taken_cnt;

  branch_unit #(.LUT_DEPTH(16), .CNT_W(CW)) dut (
    .CLK(CLK), .init_n(init_n), .instr(instr), .halt(halt), .flag_we(flag_we),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .acc_in(acc_in), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_wdata(lut_wdata), .branch_en(branch_en), .bSIGN(bSIGN),
    .bOFFSET(bOFFSET), .loop_cnt(loop_cnt), .taken_cnt(taken_cnt)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: plain integers.
  int m_z, m_n, m_loop, m_taken;
  int m_lut [16];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs implied by the current model state and current inputs.
  function automatic void model_out(output int en, output int sgn, output int off);
    int op, ix;
    op  = int'(instr[8:5]);
    ix  = int'(instr[3:0]);
    en  = 0;
    if (op == 12) en = m_z;
    if (op == 13) en = m_n;
    if (op == 14) en = 1;
    if (op == 15) en = (m_loop != 0) ? 1 : 0;
    if (halt) en = 0;
    sgn = (op >= 12) ? m_lut[ix] / 256 : 0;
    off = (op >= 12) ? m_lut[ix] % 256 : 0;
  endfunction

  always @(posedge CLK or negedge init_n) begin : model_upd
    int e, s, o;
    if (!init_n) begin
      m_z <= 0; m_n <= 0; m_loop <= 0; m_taken <= 0;
      for (int k = 0; k < 16; k++) m_lut[k] <= 0;
    end else begin
      model_out(e, s, o);
      if (lut_we) m_lut[lut_addr] <= int'(lut_wdata);
      if (!halt) begin
        if (flag_we) begin
          m_z <= int'(alu_zero);
          m_n <= int'(alu_neg);
        end
        if (instr[8:5] == 4'b1011) m_loop <= int'(acc_in);
        else if (instr[8:5] == 4'b1111 && m_loop > 0) m_loop <= m_loop - 1;
        if (e == 1 && m_taken < CMAX) m_taken <= m_taken + 1;
      end
    end
  end

  always @(negedge CLK) begin : compare
    int e, s, o;
    if (chk_en && init_n) begin
      model_out(e, s, o);
      check("cmp_branch_en", int'(branch_en), e);
      check("cmp_bSIGN", int'(bSIGN), s);
      check("cmp_bOFFSET", int'(bOFFSET), o);
      check("cmp_loop_cnt", int'(loop_cnt), m_loop);
      check("cmp_taken_cnt", int'(taken_cnt), m_taken);
    end
  end

  task automatic idle_in();
    instr = 9'd0; halt = 1'b0; flag_we = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    acc_in = 8'd0; lut_we = 1'b0; lut_addr = 4'd0; lut_wdata = 9'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [3:0] ix);
    return {op, 1'b0, ix};
  endfunction

  initial begin
    int op;
    idle_in();
    init_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1 init_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_loop_cnt", int'(loop_cnt), 0);
    check("rst_taken_cnt", int'(taken_cnt), 0);
    check("rst_branch_en", int'(branch_en), 0);

    // Write table[3] = {1, 5}, then BR through it.
    tick();
    lut_we = 1'b1; lut_addr = 4'd3; lut_wdata = 9'h105;
    tick();
    idle_in(); instr = mk(OP_BR, 4'd3);
    #1;
    check("br_en", int'(branch_en), 1);
    check("br_sign", int'(bSIGN), 1);
    check("br_off", int'(bOFFSET), 5);
    tick();
    check("br_taken", int'(taken_cnt), 1);
    check("model_taken_1", m_taken, 1);

    // Same-cycle flag write does not affect the BZ in that cycle.
    idle_in(); instr = mk(OP_BZ, 4'd3); flag_we = 1'b1; alu_zero = 1'b1;
    #1 check("bz_same_cycle", int'(branch_en), 0);
    tick();
    idle_in(); instr = mk(OP_BZ, 4'd3);
    #1 check("bz_next_cycle", int'(branch_en), 1);
    tick();

    // LDC 3 then four LOOPs: three taken, counter parks at 0.
    idle_in(); instr = mk(OP_LDC, 4'd0); acc_in = 8'd3;
    tick();
    check("ldc_cnt", int'(loop_cnt), 3);
    idle_in(); instr = mk(OP_LOOP, 4'd3);
    for (int i = 0; i < 4; i++) begin
      #1 check("loop_en", int'(branch_en), (i < 3) ? 1 : 0);
      tick();
    end
    check("loop_nowrap", int'(loop_cnt), 0);
    check("loop_taken", int'(taken_cnt), 5);
    check("model_taken_5", m_taken, 5);

    // Table write during BN through the same index reads the old entry.
    idle_in(); flag_we = 1'b1; alu_neg = 1'b1;
    lut_we = 1'b1; lut_addr = 4'd2; lut_wdata = 9'h011;
    tick();
    idle_in(); instr = mk(OP_BN, 4'd2);
    lut_we = 1'b1; lut_addr = 4'd2; lut_wdata = 9'h1AA;
    #1;
    check("bn_old_en", int'(branch_en), 1);
    check("bn_old_sign", int'(bSIGN), 0);
    check("bn_old_off", int'(bOFFSET), 17);
    tick();
    idle_in(); instr = mk(OP_BN, 4'd2);
    #1;
    check("bn_new_sign", int'(bSIGN), 1);
    check("bn_new_off", int'(bOFFSET), 170);
    tick();

    // Halt: no branch, no counter movement, table write still lands.
    idle_in(); instr = mk(OP_LDC, 4'd0); acc_in = 8'd2;
    tick();
    idle_in(); halt = 1'b1; instr = mk(OP_BR, 4'd3);
    lut_we = 1'b1; lut_addr = 4'd5; lut_wdata = 9'h007;
    #1 check("halt_br_en", int'(branch_en), 0);
    tick();
    lut_we = 1'b0; instr = mk(OP_LOOP, 4'd3);
    #1 check("halt_loop_en", int'(branch_en), 0);
    tick();
    check("halt_loop_cnt", int'(loop_cnt), 2);
    check("halt_taken", int'(taken_cnt), 7);
    idle_in(); instr = mk(OP_BR, 4'd5);
    #1;
    check("halt_lut_en", int'(branch_en), 1);
    check("halt_lut_off", int'(bOFFSET), 7);
    check("halt_lut_sign", int'(bSIGN), 0);
    tick();

    // Asynchronous reset mid-loop clears everything without a clock edge.
    idle_in(); instr = mk(OP_LDC, 4'd0); acc_in = 8'd7; flag_we = 1'b1;
    alu_zero = 1'b1; alu_neg = 1'b1;
    tick();
    idle_in(); instr = mk(OP_BZ, 4'd3);
    #1;
    check("pre_rst_cnt", int'(loop_cnt), 7);
    check("pre_rst_en", int'(branch_en), 1);
    #1 init_n = 1'b0;
    #1;
    check("arst_cnt", int'(loop_cnt), 0);
    check("arst_taken", int'(taken_cnt), 0);
    check("arst_z", int'(branch_en), 0);
    check("arst_off", int'(bOFFSET), 0);
    instr = mk(OP_BN, 4'd2);
    #1 check("arst_n", int'(branch_en), 0);
    for (int k = 0; k < 16; k++) begin
      instr = mk(OP_BR, 4'(k));
      #1;
      check("arst_lut_off", int'(bOFFSET), 0);
      check("arst_lut_sign", int'(bSIGN), 0);
      check("arst_br_en", int'(branch_en), 1);
    end
    @(posedge CLK);
    #1 init_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      op = ($urandom_range(0, 9) < 8) ? 11 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
      instr     = {4'(op), 1'($urandom), 4'($urandom)};
      acc_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      halt      = ($urandom_range(0, 9) == 0);
      flag_we   = ($urandom_range(0, 2) == 0);
      alu_zero  = 1'($urandom);
      alu_neg   = 1'($urandom);
      lut_we    = ($urandom_range(0, 3) == 0);
      lut_addr  = 4'($urandom);
      lut_wdata = 9'($urandom);
      if ($urandom_range(0, 499) == 0) init_n = 1'b0;
      tick();
      init_n = 1'b1;
    end

    // Saturation of the taken counter.
    idle_in(); instr = mk(OP_BR, 4'd1);
    repeat (CMAX + 20) tick();
    check("sat_taken", int'(taken_cnt), CMAX);
    check("model_sat", m_taken, CMAX);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
